readpixel: RTL and testbench



---
 rtl/neopixel_pkg.sv | 33 +++
 rtl/pixel_sync.sv | 30 +++
 rtl/readpixel.sv | 199 +++++++++++++++++++
 tb/tb_readpixel.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared NeoPixel definitions: pixel word layout, default line timing and
// receiver state encoding.
package neopixel_pkg;

    localparam int unsigned BITS_PER_PIXEL = 24;
    localparam int unsigned CNT_W          = 16;

    localparam int unsigned T_THRESH_NS   = 600;
    localparam int unsigned T_MIN_HIGH_NS = 200;
    localparam int unsigned T_MAX_HIGH_NS = 2000;
    localparam int unsigned T_RESET_NS    = 50_000;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2
    } rx_state_t;

    // Truncating ns -> clock-cycle conversion; 64-bit product avoids overflow.
    function automatic int unsigned ns_to_cycles(input int unsigned ns,
                                                 input int unsigned clk_hz);
        longint unsigned prod;
        prod = 64'(ns) * 64'(clk_hz);
        return 32'(prod / 64'd1_000_000_000);
    endfunction

endpackage

// File: rtl/pixel_sync.sv
// Two-flop synchronizer for the serial line with edge pulses on the
// synchronized level.
module pixel_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            meta  <= d_in;
            level <= meta;
            prev  <= level;
        end
    end

    assign rise_c = level & ~prev;
    assign fall_c = ~level & prev;

endmodule

// File: rtl/readpixel.sv
// NeoPixel serial receiver: measures high pulses, assembles 24-bit GRB words
// and flags the latch gap as end of frame.
module readpixel
    import neopixel_pkg::*;
#(
    parameter int unsigned CLK_IN_RATE_HZ = 12_000_000,
    parameter int unsigned T_THRESH_NS    = neopixel_pkg::T_THRESH_NS,
    parameter int unsigned T_MIN_HIGH_NS  = neopixel_pkg::T_MIN_HIGH_NS,
    parameter int unsigned T_MAX_HIGH_NS  = neopixel_pkg::T_MAX_HIGH_NS,
    parameter int unsigned T_RESET_NS     = neopixel_pkg::T_RESET_NS
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        d_in,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [7:0]  pixel_index,
    output logic        frame_end,
    output logic        err_glitch,
    output logic        err_long,
    output logic        err_partial,
    output logic        busy
);

    localparam int unsigned THRESH_C = ns_to_cycles(T_THRESH_NS, CLK_IN_RATE_HZ);
    localparam int unsigned MIN_C    = ns_to_cycles(T_MIN_HIGH_NS, CLK_IN_RATE_HZ);
    localparam int unsigned MAX_C    = ns_to_cycles(T_MAX_HIGH_NS, CLK_IN_RATE_HZ);
    localparam int unsigned RESET_C  = ns_to_cycles(T_RESET_NS, CLK_IN_RATE_HZ);

    localparam logic [CNT_W-1:0] THRESH_W   = CNT_W'(THRESH_C);
    localparam logic [CNT_W-1:0] MIN_W      = CNT_W'(MIN_C);
    localparam logic [CNT_W-1:0] MAX_W      = CNT_W'(MAX_C);
    localparam logic [CNT_W-1:0] RESET_W    = CNT_W'(RESET_C);
    localparam logic [CNT_W-1:0] RESET_M1_W = CNT_W'(RESET_C - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
    localparam logic [4:0]       LAST_BIT   = 5'(BITS_PER_PIXEL - 1);

    logic level;
    logic rise_c;
    logic fall_c;

    pixel_sync u_sync (
        .clk    (CLK),
        .rst_n  (RESETN),
        .d_in   (d_in),
        .level  (level),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    rx_state_t state, state_nxt;

    logic [CNT_W-1:0] hcnt, hcnt_nxt;
    logic [CNT_W-1:0] lcnt, lcnt_nxt;
    logic [4:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       pix_cnt, pix_cnt_nxt;
    logic             got_bit, got_bit_nxt;
    // The final bit of a word goes straight to the output, so only 23 are held.
    logic [BITS_PER_PIXEL-2:0] sreg, sreg_nxt;

    pixel_t     data_q, data_nxt;
    logic [7:0] index_nxt;
    logic       valid_nxt, frame_end_nxt, glitch_nxt, long_nxt, partial_nxt, busy_nxt;

    logic [CNT_W-1:0] hcnt_inc_c;
    logic [CNT_W-1:0] lcnt_inc_c;
    logic             bit_val_c;

    assign hcnt_inc_c = (hcnt == CNT_SAT) ? hcnt : hcnt + CNT_W'(1);
    assign lcnt_inc_c = (lcnt == CNT_SAT) ? lcnt : lcnt + CNT_W'(1);
    assign bit_val_c  = (hcnt >= THRESH_W);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state       <= ST_SYNC;
            hcnt        <= '0;
            lcnt        <= '0;
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            got_bit     <= 1'b0;
            sreg        <= '0;
            data_q      <= '0;
            pixel_index <= '0;
            pixel_valid <= 1'b0;
            frame_end   <= 1'b0;
            err_glitch  <= 1'b0;
            err_long    <= 1'b0;
            err_partial <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            hcnt        <= hcnt_nxt;
            lcnt        <= lcnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            pix_cnt     <= pix_cnt_nxt;
            got_bit     <= got_bit_nxt;
            sreg        <= sreg_nxt;
            data_q      <= data_nxt;
            pixel_index <= index_nxt;
            pixel_valid <= valid_nxt;
            frame_end   <= frame_end_nxt;
            err_glitch  <= glitch_nxt;
            err_long    <= long_nxt;
            err_partial <= partial_nxt;
            busy        <= busy_nxt;
        end
    end

    // Next-state and pulse decode; one line edge is handled per cycle.
    always_comb begin
        state_nxt     = state;
        hcnt_nxt      = hcnt;
        lcnt_nxt      = lcnt;
        bit_cnt_nxt   = bit_cnt;
        pix_cnt_nxt   = pix_cnt;
        got_bit_nxt   = got_bit;
        sreg_nxt      = sreg;
        data_nxt      = data_q;
        index_nxt     = pixel_index;
        valid_nxt     = 1'b0;
        frame_end_nxt = 1'b0;
        glitch_nxt    = 1'b0;
        long_nxt      = 1'b0;
        partial_nxt   = 1'b0;

        unique case (state)
            ST_SYNC: begin
                if (level) begin
                    lcnt_nxt = '0;
                end else begin
                    lcnt_nxt = lcnt_inc_c;
                    if (lcnt_inc_c >= RESET_W) begin
                        state_nxt   = ST_IDLE;
                        bit_cnt_nxt = '0;
                        pix_cnt_nxt = '0;
                        sreg_nxt    = '0;
                        got_bit_nxt = 1'b0;
                    end
                end
            end
            ST_IDLE: begin
                if (rise_c) begin
                    hcnt_nxt  = CNT_W'(1);
                    lcnt_nxt  = '0;
                    state_nxt = ST_HIGH;
                end else if (!level) begin
                    lcnt_nxt = lcnt_inc_c;
                    // Exact match makes the gap pulses fire once even while lcnt saturates.
                    if (lcnt == RESET_M1_W) begin
                        frame_end_nxt = got_bit;
                        partial_nxt   = (bit_cnt != '0);
                        got_bit_nxt   = 1'b0;
                        bit_cnt_nxt   = '0;
                        sreg_nxt      = '0;
                        pix_cnt_nxt   = '0;
                    end
                end
            end
            ST_HIGH: begin
                if (fall_c) begin
                    lcnt_nxt = CNT_W'(1);
                    if (hcnt < MIN_W) begin
                        glitch_nxt  = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = ST_SYNC;
                    end else begin
                        state_nxt   = ST_IDLE;
                        got_bit_nxt = 1'b1;
                        sreg_nxt    = {sreg[BITS_PER_PIXEL-3:0], bit_val_c};
                        if (bit_cnt == LAST_BIT) begin
                            data_nxt    = pixel_t'({sreg, bit_val_c});
                            valid_nxt   = 1'b1;
                            index_nxt   = pix_cnt;
                            pix_cnt_nxt = (pix_cnt == 8'hFF) ? pix_cnt : pix_cnt + 8'd1;
                            bit_cnt_nxt = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 5'd1;
                        end
                    end
                end else if (hcnt >= MAX_W) begin
                    long_nxt    = 1'b1;
                    bit_cnt_nxt = '0;
                    lcnt_nxt    = '0;
                    state_nxt   = ST_SYNC;
                end else begin
                    hcnt_nxt = hcnt_inc_c;
                end
            end
            default: begin
                state_nxt = ST_SYNC;
            end
        endcase

        busy_nxt = (state_nxt != ST_SYNC) && (bit_cnt_nxt != '0);
    end

    assign pixel_data = data_q;

endmodule

// File: tb/tb_readpixel.sv
// Directed bench for readpixel: decodes hand-built pulse trains and checks
// words, indices, gap pulses, error pulses and reset behaviour.
module tb_readpixel;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        d_in = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [7:0]  pixel_index;
    logic        frame_end;
    logic        err_glitch;
    logic        err_long;
    logic        err_partial;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    int pv_cnt = 0, fe_cnt = 0, gl_cnt = 0, lg_cnt = 0, pt_cnt = 0;
    logic [23:0] data_q[$];
    logic [7:0]  idx_q[$];

    readpixel dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .d_in        (d_in),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_end   (frame_end),
        .err_glitch  (err_glitch),
        .err_long    (err_long),
        .err_partial (err_partial),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    // Pulse monitor, sampled just after each rising edge.
    always @(posedge CLK) begin
        #1;
        if (pixel_valid) begin
            pv_cnt++;
            data_q.push_back(pixel_data);
            idx_q.push_back(pixel_index);
        end
        if (frame_end)   fe_cnt++;
        if (err_glitch)  gl_cnt++;
        if (err_long)    lg_cnt++;
        if (err_partial) pt_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic low(input int n);
        d_in = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse(input int h);
        d_in = 1'b1;
        repeat (h) @(negedge CLK);
        low(10);
    endtask

    task automatic send_bits(input logic [23:0] w, input int nbits);
        logic [23:0] v;
        v = w;
        for (int i = nbits - 1; i >= 0; i--) pulse(v[i] ? 10 : 5);
    endtask

    // Counts rising edges until the chosen pulse is seen (0: frame_end, 1: err_long).
    task automatic wait_pulse(input int which, input int maxc, output int n, output logic partial);
        logic hit;
        n = 0;
        partial = 1'b0;
        hit = 1'b0;
        while (!hit && n < maxc) begin
            @(posedge CLK);
            #1;
            n++;
            hit = (which == 0) ? frame_end : err_long;
            partial = err_partial;
        end
    endtask

    initial begin
        int pv0, fe0, gl0, lg0, pt0, n;
        logic part;

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset_data", 32'(pixel_data), 32'h0);
        check("reset_flags", 32'({pixel_valid, frame_end, err_glitch, err_long, err_partial, busy}), 32'h0);
        check("reset_index", 32'(pixel_index), 32'h0);
        RESETN = 1'b1;
        low(610);

        // Single word
        pv0 = pv_cnt; gl0 = gl_cnt; lg0 = lg_cnt;
        send_bits(24'hA53CF0, 24);
        check("w1_count", 32'(pv_cnt - pv0), 32'd1);
        check("w1_data", 32'(data_q[$]), 32'hA53CF0);
        check("w1_index", 32'(idx_q[$]), 32'd0);
        check("w1_errs", 32'((gl_cnt - gl0) + (lg_cnt - lg0)), 32'd0);
        check("w1_busy", 32'(busy), 32'd0);

        // Two more words then the latch gap
        pv0 = pv_cnt; fe0 = fe_cnt; pt0 = pt_cnt;
        send_bits(24'h123456, 24);
        send_bits(24'hFEDCBA, 24);
        check("w2_count", 32'(pv_cnt - pv0), 32'd2);
        check("w2_data0", 32'(data_q[data_q.size() - 2]), 32'h123456);
        check("w2_index0", 32'(idx_q[idx_q.size() - 2]), 32'd1);
        check("w2_data1", 32'(data_q[$]), 32'hFEDCBA);
        check("w2_index1", 32'(idx_q[$]), 32'd2);
        wait_pulse(0, 1000, n, part);
        check("gap_latency", 32'(n + 10), 32'd602);
        @(negedge CLK);
        low(20);
        check("gap_fe_once", 32'(fe_cnt - fe0), 32'd1);
        check("gap_no_partial", 32'(pt_cnt - pt0), 32'd0);

        // Pulse-width boundaries: 6->0, 7->1, 2->0, 24->1
        pv0 = pv_cnt; gl0 = gl_cnt; lg0 = lg_cnt;
        pulse(6); pulse(7); pulse(2); pulse(24);
        send_bits(24'h0ABCDE, 20);
        check("thr_count", 32'(pv_cnt - pv0), 32'd1);
        check("thr_data", 32'(data_q[$]), 32'h5ABCDE);
        check("thr_index", 32'(idx_q[$]), 32'd0);
        check("thr_errs", 32'((gl_cnt - gl0) + (lg_cnt - lg0)), 32'd0);

        // Over-long high pulse
        lg0 = lg_cnt;
        d_in = 1'b1;
        wait_pulse(1, 100, n, part);
        check("long_latency", 32'(n), 32'd27);
        @(negedge CLK);
        low(610);
        check("long_count", 32'(lg_cnt - lg0), 32'd1);
        check("long_busy", 32'(busy), 32'd0);

        // Glitch mid-word, then resynchronize
        pv0 = pv_cnt; gl0 = gl_cnt;
        send_bits(24'h0000A5, 8);
        check("mid_busy", 32'(busy), 32'd1);
        pulse(1);
        check("glitch_count", 32'(gl_cnt - gl0), 32'd1);
        check("glitch_busy", 32'(busy), 32'd0);
        send_bits(24'h777777, 24);
        check("glitch_no_valid", 32'(pv_cnt - pv0), 32'd0);
        low(610);
        send_bits(24'h0F1E2D, 24);
        check("resync_count", 32'(pv_cnt - pv0), 32'd1);
        check("resync_data", 32'(data_q[$]), 32'h0F1E2D);
        check("resync_index", 32'(idx_q[$]), 32'd0);

        // Partial word at the latch gap
        pv0 = pv_cnt; fe0 = fe_cnt; pt0 = pt_cnt;
        send_bits(24'h0002AB, 10);
        check("part_busy", 32'(busy), 32'd1);
        wait_pulse(0, 1000, n, part);
        check("part_same_cycle", 32'(part), 32'd1);
        @(negedge CLK);
        low(20);
        check("part_fe_count", 32'(fe_cnt - fe0), 32'd1);
        check("part_count", 32'(pt_cnt - pt0), 32'd1);
        send_bits(24'h00FF00, 24);
        check("part_next_data", 32'(data_q[$]), 32'h00FF00);
        check("part_next_index", 32'(idx_q[$]), 32'd0);

        // Asynchronous reset mid-pixel
        pv0 = pv_cnt; pt0 = pt_cnt;
        send_bits(24'h000ABC, 12);
        RESETN = 1'b0;
        #1;
        check("rst_data", 32'(pixel_data), 32'h0);
        check("rst_flags", 32'({pixel_valid, frame_end, err_glitch, err_long, err_partial, busy}), 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
        low(10);
        send_bits(24'h336699, 24);
        check("rst_no_valid", 32'(pv_cnt - pv0), 32'd0);
        low(610);
        send_bits(24'hC0FFEE, 24);
        check("rst_resume_count", 32'(pv_cnt - pv0), 32'd1);
        check("rst_resume_data", 32'(data_q[$]), 32'hC0FFEE);
        check("rst_resume_index", 32'(idx_q[$]), 32'd0);
        check("rst_no_partial", 32'(pt_cnt - pt0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
